// File: rtl/seg8_scan_driver.sv
// Eight-digit common-anode seven-segment scan driver with blanking gap between digits.
// Optional decimal-point support is enabled by defining SEG8_DP_EN.
module seg8_scan_driver #(
    parameter int CLK_HZ       = 100000000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
`ifdef SEG8_DP_EN
    input  logic       wr_dp,
`endif
    input  logic [7:0] digit_en,
    output logic [7:0] an,
    output logic [6:0] seg,
`ifdef SEG8_DP_EN
    output logic       dp,
`endif
    output logic [2:0] scan_idx,
    output logic       frame_tick
);

    localparam int SLOT         = CLK_HZ / (REFRESH_HZ * 8);
    localparam int DRIVE_CYCLES = SLOT - BLANK_CYCLES;
    localparam int TIMER_W      = $clog2(SLOT + 1);
`ifdef SEG8_DP_EN
    localparam int DW = 5;
`else
    localparam int DW = 4;
`endif
    localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DRIVE_LAST = TIMER_W'(DRIVE_CYCLES - 1);

    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SLOT) begin : g_bad_params
            $error("seg8_scan_driver: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < SLOT");
        end
    endgenerate

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         scanIdx_q, scanIdx_d;
    logic               frameTick_q, frameTick_d;
    logic [7:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [DW-1:0]      digit_q [8];
    logic [DW-1:0]      curDigit;
    logic [7:0]         driveAn;
    logic               curDpLit;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) digit_q[i] <= '0;
        end else if (wr_en) begin
`ifdef SEG8_DP_EN
            digit_q[wr_addr] <= {wr_dp, wr_data};
`else
            digit_q[wr_addr] <= wr_data;
`endif
        end
    end

    assign curDigit = digit_q[scanIdx_q];
    assign driveAn  = digit_en[scanIdx_q] ? ~(8'h01 << scanIdx_q) : 8'hFF;
`ifdef SEG8_DP_EN
    assign curDpLit = curDigit[4];
`else
    assign curDpLit = 1'b0;
`endif

    // Outputs are computed one cycle early so they switch on the same edge as the state.
    // seg_q/dp_q double as the shadow: loaded once at BLANK->DRIVE, held through DRIVE.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        scanIdx_d   = scanIdx_q;
        frameTick_d = 1'b0;
        an_d        = 8'hFF;
        seg_d       = 7'h7F;
        dp_d        = 1'b1;
        case (state_q)
            BLANK: begin
                if (timer_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    timer_d = '0;
                    an_d    = driveAn;
                    seg_d   = decode(curDigit[3:0]);
                    dp_d    = ~curDpLit;
                end
            end
            DRIVE: begin
                an_d  = driveAn;
                seg_d = seg_q;
                dp_d  = dp_q;
                if (timer_q == DRIVE_LAST) begin
                    state_d     = BLANK;
                    timer_d     = '0;
                    scanIdx_d   = scanIdx_q + 3'd1;
                    frameTick_d = (scanIdx_q == 3'd7);
                    an_d        = 8'hFF;
                    seg_d       = 7'h7F;
                    dp_d        = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BLANK;
            timer_q     <= '0;
            scanIdx_q   <= 3'd0;
            frameTick_q <= 1'b0;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            scanIdx_q   <= scanIdx_d;
            frameTick_q <= frameTick_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign scan_idx   = scanIdx_q;
    assign frame_tick = frameTick_q;
`ifdef SEG8_DP_EN
    assign dp         = dp_q;
`endif

endmodule

// File: tb/tb_seg8_scan_driver.sv
// Directed bench for seg8_scan_driver: 8-cycle slots (2 blank + 6 drive), slot-level vector table.
// Also exercises the SEG8_DP_EN decimal point when that macro is defined.
module tb_seg8_scan_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'd0;
    logic [7:0] digit_en = 8'hFF;
    logic [7:0] an;
    logic [6:0] seg;
    logic [2:0] scan_idx;
    logic       frame_tick;
`ifdef SEG8_DP_EN
    logic       wr_dp = 1'b0;
    logic       dp;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] digitEn;
        logic       wrEn;
        int         wrPhase;
        logic [2:0] wrAddr;
        logic [3:0] wrData;
        logic       wrDp;
        logic [7:0] expAn;
        logic [6:0] expSeg;
        logic       expDp;
    } slotVec_t;

    slotVec_t   vecs [32];
    logic [6:0] code [16];

    seg8_scan_driver #(
        .CLK_HZ(64000),
        .REFRESH_HZ(1000),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
`ifdef SEG8_DP_EN
        .wr_dp(wr_dp),
        .dp(dp),
`endif
        .digit_en(digit_en),
        .an(an),
        .seg(seg),
        .scan_idx(scan_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input slotVec_t v, input int phase);
        digit_en = v.digitEn;
        if (v.wrEn && phase == v.wrPhase) begin
            wr_en   = 1'b1;
            wr_addr = v.wrAddr;
            wr_data = v.wrData;
`ifdef SEG8_DP_EN
            wr_dp   = v.wrDp;
`endif
        end else begin
            wr_en = 1'b0;
        end
    endtask

    task automatic checkCycle(input logic [7:0] expAn, input logic [6:0] expSeg, input logic expDp,
                              input logic [2:0] expIdx);
        checkOutput("an", an, expAn);
        checkOutput("seg", {1'b0, seg}, {1'b0, expSeg});
        checkOutput("scan_idx", {5'd0, scan_idx}, {5'd0, expIdx});
        checkOutput("frame_tick", {7'd0, frame_tick}, {7'd0, (cyc > 0 && cyc % 64 == 0)});
        checkOutput("one_anode", {7'd0, ($countones(~an) <= 1)}, 8'd1);
`ifdef SEG8_DP_EN
        checkOutput("dp", {7'd0, dp}, {7'd0, expDp});
`else
        if (expDp !== 1'b0 && expDp !== 1'b1) $display("[TB] note: undefined dp expectation");
`endif
    endtask

    initial begin
        code = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Frame 0 loads digit s with s+1 during its own blank; frame 1 darkens digit 3;
        // frame 2 writes mid-drive and on the capture edge; frame 3 shows the new values.
        for (int s = 0; s < 8; s++) begin
            vecs[s]      = '{8'hFF, 1'b1, 0, 3'(s), 4'(s + 1), (s == 2),
                             8'(~(8'h01 << s)), code[s + 1], (s != 2)};
            vecs[8 + s]  = '{8'hF7, 1'b0, 0, 3'd0, 4'd0, 1'b0,
                             (s == 3) ? 8'hFF : 8'(~(8'h01 << s)), code[s + 1], (s != 2)};
            vecs[16 + s] = '{8'hFF, 1'b0, 0, 3'd0, 4'd0, 1'b0,
                             8'(~(8'h01 << s)), code[s + 1], (s != 2)};
            vecs[24 + s] = vecs[16 + s];
        end
        vecs[16] = '{8'hFF, 1'b1, 4, 3'd0, 4'hF, 1'b0, 8'hFE, 7'h79, 1'b1};
        vecs[17] = '{8'hFF, 1'b1, 1, 3'd1, 4'h0, 1'b0, 8'hFD, 7'h24, 1'b1};
        vecs[24].expSeg = 7'h0E;
        vecs[25].expSeg = 7'h40;

        // Reset held: outputs at reset values even across clock edges.
        repeat (3) @(negedge clk);
        checkOutput("rst_an", an, 8'hFF);
        checkOutput("rst_seg", {1'b0, seg}, 8'h7F);
        checkOutput("rst_idx", {5'd0, scan_idx}, 8'd0);
        checkOutput("rst_tick", {7'd0, frame_tick}, 8'd0);

        // Release with all digits zero: slot 0 then slot 1.
        reset = 1'b1;
        cyc = 0;
        for (int k = 0; k < 16; k++) begin
            if (k % 8 < 2) checkCycle(8'hFF, 7'h7F, 1'b1, 3'(k / 8));
            else           checkCycle(8'(~(8'h01 << (k / 8))), 7'h40, 1'b1, 3'(k / 8));
            @(negedge clk);
            cyc++;
        end

        // Re-sync by reset, then run the slot table over four frames.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        for (int i = 0; i < 32; i++) begin
            for (int p = 0; p < 8; p++) begin
                applyStimulus(vecs[i], p);
                if (p < 2) checkCycle(8'hFF, 7'h7F, 1'b1, 3'(i % 8));
                else       checkCycle(vecs[i].expAn, vecs[i].expSeg, vecs[i].expDp, 3'(i % 8));
                @(negedge clk);
                cyc++;
            end
        end
        wr_en = 1'b0;
        digit_en = 8'hFF;

        // Reset asserted mid-drive of digit 5 (value 6): outputs clear without a clock edge.
        repeat (44) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("d5_an", an, 8'hDF);
        checkOutput("d5_seg", {1'b0, seg}, 8'h02);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_an", an, 8'hFF);
        checkOutput("async_seg", {1'b0, seg}, 8'h7F);
        checkOutput("async_idx", {5'd0, scan_idx}, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        for (int k = 0; k < 16; k++) begin
            if (k % 8 < 2) checkCycle(8'hFF, 7'h7F, 1'b1, 3'(k / 8));
            else           checkCycle(8'(~(8'h01 << (k / 8))), 7'h40, 1'b1, 3'(k / 8));
            @(negedge clk);
            cyc++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
